spi_slave_fifo_bridge: RTL and testbench

- Sits between `spi_slave` and the host bus, on the slave's `Clk` domain.
- Pushes each completed SPI receive word into an RX FIFO for the host.
- Supplies `spi_slave`'s `TxData` from a host-filled TX FIFO, popping one word per SPI frame.
- Keeps sticky overflow/underrun flags and fill counts for software.

---
 rtl/spi_slave_fifo_bridge.sv | 137 +++++++++++++
 tb/tb_spi_slave_fifo_bridge.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_fifo_bridge.sv
// Bridges spi_slave receive/transmit words to host-side RX and TX FIFOs.
// It also keeps sticky overflow/underrun flags and occupancy counts for software.
module spi_slave_fifo_bridge #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    DEPTH      = 4,
   parameter logic [DATA_WIDTH-1:0] FILL_WORD  = 8'hFF
) (
   input  logic                        Clk,
   input  logic                        Rst,
   input  logic                        SS,
   input  logic                        Done,
   input  logic [DATA_WIDTH-1:0]       RxData,
   output logic [DATA_WIDTH-1:0]       TxData,
   output logic [DATA_WIDTH-1:0]       RxRdData,
   output logic                        RxRdValid,
   input  logic                        RxRdReady,
   input  logic [DATA_WIDTH-1:0]       TxWrData,
   input  logic                        TxWrValid,
   output logic                        TxWrReady,
   output logic [$clog2(DEPTH):0]      RxCount,
   output logic [$clog2(DEPTH):0]      TxCount,
   output logic                        RxOverflow,
   output logic                        TxUnderrun,
   input  logic                        ClrFlags
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic                  done_q_r, ss_q_r;
   logic [DATA_WIDTH-1:0] rx_mem_r [DEPTH];
   logic [DATA_WIDTH-1:0] tx_mem_r [DEPTH];
   logic [AW-1:0]         rx_wr_ptr_r, rx_rd_ptr_r, tx_wr_ptr_r, tx_rd_ptr_r;
   logic [CW-1:0]         rx_count_r, tx_count_r;
   logic [DATA_WIDTH-1:0] tx_data_r;
   logic                  rx_ovf_r, tx_udr_r;

   logic rx_evt_s, frame_start_s, rx_full_s, tx_full_s, tx_empty_s;
   logic rx_pop_s, rx_push_s, rx_drop_s, tx_pop_s, tx_push_s, tx_udr_set_s;

   // Event decode; a pop can free the slot that a same-cycle push needs.
   always_comb begin
      rx_evt_s      = Done & ~done_q_r & ~SS;
      frame_start_s = ss_q_r & ~SS;
      rx_full_s     = (rx_count_r == FULL_CNT);
      tx_full_s     = (tx_count_r == FULL_CNT);
      tx_empty_s    = (tx_count_r == {CW{1'b0}});
      rx_pop_s      = (rx_count_r != {CW{1'b0}}) & RxRdReady;
      rx_push_s     = rx_evt_s & (~rx_full_s | rx_pop_s);
      rx_drop_s     = rx_evt_s & rx_full_s & ~rx_pop_s;
      tx_pop_s      = frame_start_s & ~tx_empty_s;
      tx_udr_set_s  = frame_start_s & tx_empty_s;
      tx_push_s     = TxWrValid & (~tx_full_s | tx_pop_s);
   end

   // Edge-detect history, sticky flags and the registered transmit word.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         done_q_r  <= 1'b0;
         ss_q_r    <= 1'b1;
         rx_ovf_r  <= 1'b0;
         tx_udr_r  <= 1'b0;
         tx_data_r <= FILL_WORD;
      end else begin
         done_q_r  <= Done;
         ss_q_r    <= SS;
         rx_ovf_r  <= rx_drop_s | (rx_ovf_r & ~ClrFlags);
         tx_udr_r  <= tx_udr_set_s | (tx_udr_r & ~ClrFlags);
         tx_data_r <= tx_empty_s ? FILL_WORD : tx_mem_r[tx_rd_ptr_r];
      end
   end

   // RX FIFO pointers and occupancy.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         rx_wr_ptr_r <= {AW{1'b0}};
         rx_rd_ptr_r <= {AW{1'b0}};
         rx_count_r  <= {CW{1'b0}};
      end else begin
         if (rx_push_s) begin
            rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
         end
         if (rx_pop_s) begin
            rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
         end
         case ({rx_push_s, rx_pop_s})
            2'b10:   rx_count_r <= rx_count_r + CNT_ONE;
            2'b01:   rx_count_r <= rx_count_r - CNT_ONE;
            default: rx_count_r <= rx_count_r;
         endcase
      end
   end

   // TX FIFO pointers and occupancy.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         tx_wr_ptr_r <= {AW{1'b0}};
         tx_rd_ptr_r <= {AW{1'b0}};
         tx_count_r  <= {CW{1'b0}};
      end else begin
         if (tx_push_s) begin
            tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
         end
         if (tx_pop_s) begin
            tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
         end
         case ({tx_push_s, tx_pop_s})
            2'b10:   tx_count_r <= tx_count_r + CNT_ONE;
            2'b01:   tx_count_r <= tx_count_r - CNT_ONE;
            default: tx_count_r <= tx_count_r;
         endcase
      end
   end

   // Storage arrays carry no reset; validity is tracked by the counts.
   always_ff @(posedge Clk) begin
      if (rx_push_s) begin
         rx_mem_r[rx_wr_ptr_r] <= RxData;
      end
      if (tx_push_s) begin
         tx_mem_r[tx_wr_ptr_r] <= TxWrData;
      end
   end

   assign TxData     = tx_data_r;
   assign RxRdData   = rx_mem_r[rx_rd_ptr_r];
   assign RxRdValid  = (rx_count_r != {CW{1'b0}});
   assign TxWrReady  = ~tx_full_s;
   assign RxCount    = rx_count_r;
   assign TxCount    = tx_count_r;
   assign RxOverflow = rx_ovf_r;
   assign TxUnderrun = tx_udr_r;

endmodule

// File: tb/tb_spi_slave_fifo_bridge.sv
// Directed plus randomized bench for spi_slave_fifo_bridge.
// A queue-based reference model predicts every output each cycle.
`timescale 1ns/1ps
module tb_spi_slave_fifo_bridge;

   localparam int DEPTH = 4;
   localparam logic [7:0] FILL = 8'hFF;

   logic       Clk = 1'b0;
   logic       Rst, SS, Done, RxRdReady, TxWrValid, ClrFlags;
   logic [7:0] RxData, TxWrData, TxData, RxRdData;
   logic       RxRdValid, TxWrReady, RxOverflow, TxUnderrun;
   logic [2:0] RxCount, TxCount;

   spi_slave_fifo_bridge #(.DATA_WIDTH(8), .DEPTH(DEPTH), .FILL_WORD(FILL)) dut (
      .Clk(Clk), .Rst(Rst), .SS(SS), .Done(Done), .RxData(RxData), .TxData(TxData),
      .RxRdData(RxRdData), .RxRdValid(RxRdValid), .RxRdReady(RxRdReady),
      .TxWrData(TxWrData), .TxWrValid(TxWrValid), .TxWrReady(TxWrReady),
      .RxCount(RxCount), .TxCount(TxCount), .RxOverflow(RxOverflow),
      .TxUnderrun(TxUnderrun), .ClrFlags(ClrFlags)
   );

   always #5 Clk = ~Clk;

   int total = 0;
   int bad   = 0;

   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];
   logic [7:0] sent[$];
   logic       m_ovf, m_udr, m_done, m_ss;
   logic [7:0] m_txd;
   bit         rnd_host = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("rx_count", 32'(RxCount), rx_q.size());
      chk("rx_valid", 32'(RxRdValid), 32'(rx_q.size() != 0));
      if (rx_q.size() != 0) chk("rx_head", 32'(RxRdData), 32'(rx_q[0]));
      chk("tx_count", 32'(TxCount), tx_q.size());
      chk("tx_ready", 32'(TxWrReady), 32'(tx_q.size() != DEPTH));
      chk("tx_data", 32'(TxData), 32'(m_txd));
      chk("rx_ovf", 32'(RxOverflow), 32'(m_ovf));
      chk("tx_udr", 32'(TxUnderrun), 32'(m_udr));
   endtask

   // Apply one clock of the reference model, then compare after the edge.
   task automatic step();
      bit rx_evt, fs, rpop, rfull, tpop, tempty, twr;
      if (rnd_host) begin
         RxRdReady = ($urandom_range(0, 1) == 1);
         TxWrValid = ($urandom_range(0, 2) == 0);
         TxWrData  = 8'($urandom);
         ClrFlags  = ($urandom_range(0, 15) == 0);
      end
      rx_evt = Done && !m_done && !SS;
      fs     = m_ss && !SS;
      if (Rst) begin
         rx_q.delete(); tx_q.delete();
         m_ovf = 1'b0; m_udr = 1'b0; m_txd = FILL; m_done = 1'b0; m_ss = 1'b1;
      end else begin
         rpop   = (rx_q.size() > 0) && RxRdReady;
         rfull  = (rx_q.size() == DEPTH);
         tempty = (tx_q.size() == 0);
         tpop   = fs && !tempty;
         twr    = TxWrValid && (tx_q.size() < DEPTH || tpop);
         m_txd  = tempty ? FILL : tx_q[0];
         if (rpop) void'(rx_q.pop_front());
         if (rx_evt && (!rfull || rpop)) rx_q.push_back(RxData);
         if (tpop) void'(tx_q.pop_front());
         if (twr) tx_q.push_back(TxWrData);
         m_ovf  = (rx_evt && rfull && !rpop) ? 1'b1 : (ClrFlags ? 1'b0 : m_ovf);
         m_udr  = (fs && tempty) ? 1'b1 : (ClrFlags ? 1'b0 : m_udr);
         m_done = Done;
         m_ss   = SS;
      end
      @(posedge Clk);
      #1;
      check_all();
   endtask

   // One SPI frame as seen by the bridge; records the word the slave would send.
   task automatic frame(input logic [7:0] d, input int hold, input bit pop_at_evt,
                        input bit wr_at_start, input logic [7:0] wd);
      sent.push_back(TxData);
      SS = 1'b0;
      if (wr_at_start) begin
         TxWrValid = 1'b1;
         TxWrData  = wd;
      end
      step();
      TxWrValid = 1'b0;
      repeat ($urandom_range(1, 3)) step();
      Done = 1'b1;
      RxData = d;
      if (pop_at_evt) RxRdReady = 1'b1;
      step();
      RxRdReady = 1'b0;
      repeat (hold - 1) step();
      SS = 1'b1;
      Done = 1'b0;
      step();
      step();
   endtask

   task automatic host_write(input logic [7:0] d);
      TxWrValid = 1'b1;
      TxWrData  = d;
      step();
      TxWrValid = 1'b0;
   endtask

   initial begin
      Rst = 1'b1; SS = 1'b1; Done = 1'b0; RxData = 8'h00; RxRdReady = 1'b0;
      TxWrData = 8'h00; TxWrValid = 1'b0; ClrFlags = 1'b0;
      step(); step();
      Rst = 1'b0;
      step();
      chk("reset_txdata", 32'(TxData), 32'h0000_00FF);
      chk("reset_ready", 32'(TxWrReady), 32'd1);

      // RX path, Done held for 20 cycles per frame
      frame(8'hA5, 20, 1'b0, 1'b0, 8'h00);
      frame(8'h3C, 20, 1'b0, 1'b0, 8'h00);
      frame(8'h81, 20, 1'b0, 1'b0, 8'h00);
      chk("rx_three", 32'(RxCount), 32'd3);
      chk("rx_first", 32'(RxRdData), 32'h0000_00A5);
      RxRdReady = 1'b1;
      repeat (4) step();
      RxRdReady = 1'b0;

      // RX overflow
      for (int i = 1; i <= 5; i++) frame(8'(i), 3, 1'b0, 1'b0, 8'h00);
      chk("ovf_count", 32'(RxCount), 32'd4);
      chk("ovf_flag", 32'(RxOverflow), 32'd1);
      RxRdReady = 1'b1;
      repeat (4) step();
      RxRdReady = 1'b0;
      ClrFlags = 1'b1;
      step();
      ClrFlags = 1'b0;
      step();
      chk("ovf_clear", 32'(RxOverflow), 32'd0);

      // TX path
      host_write(8'h11);
      host_write(8'h22);
      step(); step();
      sent.delete();
      repeat (3) frame(8'h00, 2, 1'b0, 1'b0, 8'h00);
      chk("tx_word0", 32'(sent[0]), 32'h0000_0011);
      chk("tx_word1", 32'(sent[1]), 32'h0000_0022);
      chk("tx_word2", 32'(sent[2]), 32'h0000_00FF);
      chk("tx_underrun", 32'(TxUnderrun), 32'd1);
      chk("tx_empty", 32'(TxCount), 32'd0);
      ClrFlags = 1'b1;
      step();
      ClrFlags = 1'b0;
      RxRdReady = 1'b1;
      repeat (4) step();
      RxRdReady = 1'b0;

      // Simultaneous events on full FIFOs
      for (int i = 0; i < 4; i++) frame(8'hC0 + 8'(i), 2, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) host_write(8'h50 + 8'(i));
      step();
      frame(8'hEE, 2, 1'b1, 1'b1, 8'h77);
      chk("rx_full_pop", 32'(RxCount), 32'd4);
      chk("rx_no_ovf", 32'(RxOverflow), 32'd0);
      chk("tx_full_wr", 32'(TxCount), 32'd4);

      // Reset mid-frame
      SS = 1'b0; Done = 1'b1; RxData = 8'h99;
      step();
      Rst = 1'b1;
      step();
      Rst = 1'b0; SS = 1'b1; Done = 1'b0;
      step();
      chk("mid_rst_rx", 32'(RxCount), 32'd0);
      chk("mid_rst_tx", 32'(TxCount), 32'd0);
      chk("mid_rst_txd", 32'(TxData), 32'h0000_00FF);
      frame(8'h5A, 4, 1'b0, 1'b0, 8'h00);
      chk("post_rst_push", 32'(RxRdData), 32'h0000_005A);

      // Randomized host traffic against random frames
      rnd_host = 1'b1;
      for (int i = 0; i < 30; i++) begin
         frame(8'($urandom), $urandom_range(1, 6), 1'b0, 1'b0, 8'h00);
         repeat ($urandom_range(0, 3)) step();
      end
      rnd_host = 1'b0;
      RxRdReady = 1'b0; TxWrValid = 1'b0; ClrFlags = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
